// File: rtl/piso_pkg.sv
// Shared definitions for the framed serial transmitter and its future receiver.
package piso_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        DATA  = ST_DATA,
        STOP  = ST_STOP
    } state_t;

    // A counter for a range of one value still needs one bit.
    function automatic int clog2_safe(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/piso_tx_bit_timer.sv
// Bit-period timer: tick marks the last cycle of each CLKS_PER_BIT-cycle bit.
import piso_pkg::*;

module bit_timer #(
    parameter int CLKS_PER_BIT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = clog2_safe(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out framed transmitter: start bit, WIDTH data bits, stop bit.
import piso_pkg::*;

module piso_tx #(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 2,
    parameter int MSB_FIRST    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int BC_W = $clog2(WIDTH) + 1;
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic              sout_q, sout_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept;
    logic              tick;
    logic [WIDTH-1:0]  shifted;

    function automatic logic out_bit(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction

    assign in_ready = (state_q == IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign shifted  = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
    assign sout     = sout_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // Held clear while idle so the first start-bit cycle begins at count 0.
    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(accept || (state_q == IDLE)),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        sout_d    = sout_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                sout_d = 1'b1;
                busy_d = 1'b0;
                if (accept) begin
                    shreg_d   = in;
                    bit_cnt_d = '0;
                    state_d   = START;
                    sout_d    = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    sout_d  = out_bit(shreg_q);
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_d   = shifted;
                    bit_cnt_d = bit_cnt_q + BC_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = STOP;
                        sout_d  = 1'b1;
                    end else begin
                        sout_d = out_bit(shifted);
                    end
                end
            end
            STOP: begin
                sout_d = 1'b1;
                if (tick) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                sout_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            sout_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            sout_q    <= sout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

endmodule
